agc_lfsr_gen: RTL
=================

AGC_LFSR_GEN -- requirements
Module: agc_lfsr_gen

Interface
REQ-001 SHALL have parameter LFSR_LEN, default 35: LFSR length in bits, range 5..64.
REQ-002 SHALL have parameter TAP, default 33: second feedback tap, 1-based, TAP < LFSR_LEN.
REQ-003 SHALL have parameter NBITS, default 4: LFSR steps per advancing clock, range 1..8.
REQ-004 SHALL have parameter SEED, default 1: nonzero power-up and fallback seed, LFSR_LEN bits.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk_i, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start_i, input, 1 bit: IDLE->RUN request.
REQ-009 SHALL have port stop_i, input, 1 bit: RUN->IDLE request; state is retained.
REQ-010 SHALL have port en_i, input, 1 bit: advance enable while in RUN.
REQ-011 SHALL have port seed_wr_i, input, 1 bit: load seed_i into the state.
REQ-012 SHALL have port seed_i, input, LFSR_LEN bits: seed value.
REQ-013 SHALL have port out_o, output, NBITS bits: generated bits; out_o[0] is the oldest.
REQ-014 SHALL have port valid_o, output, 1 bit: out_o holds new bits this cycle.
REQ-015 SHALL have port lockup_o, output, 1 bit: one-cycle pulse on a zero-state recovery.
REQ-016 SHALL have port wrap_o, output, 1 bit: one-cycle pulse when the state returns to the last loaded seed.
REQ-017 SHALL have port running_o, output, 1 bit: FSM is in RUN.

Function
REQ-018 SHALL define one step as: new bit b = x[LFSR_LEN-1] ^ x[TAP-1]; then x <= {x[LFSR_LEN-2:0], b}.
REQ-019 SHALL, in RUN with en_i=1, apply NBITS steps in one clock; out_o[k] = the bit from step k; valid_o=1 on the next cycle (1-cycle latency); otherwise valid_o=0 and out_o holds its value.
REQ-020 SHALL implement FSM states IDLE and RUN: start_i in IDLE -> RUN; stop_i in RUN -> IDLE; stop_i wins over a simultaneous start_i.
REQ-021 SHALL apply seed_wr_i in either state: the state loads seed_i, there is no advance that cycle, and it takes priority over en_i.
REQ-022 SHALL, when a seed_wr_i value is all-zero, load SEED instead and pulse lockup_o.
REQ-023 SHALL, if the state is all-zero in RUN, reload SEED instead of advancing, pulse lockup_o, and hold valid_o=0.
REQ-024 SHALL pulse wrap_o when any of the NBITS intermediate states in an advancing cycle equals the last loaded seed (SEED after reset).
REQ-025 SHALL hold the state, out_o and valid_o=0 while in IDLE.

Reset
REQ-026 SHALL, on rst_i, set FSM=IDLE, state=SEED, stored seed=SEED, out_o=0, and valid_o, lockup_o, wrap_o and running_o=0.
REQ-027 SHALL give rst_i priority over every input; a reset mid-RUN discards the in-flight bits and the next cycle shows valid_o=0.

Configuration
REQ-028 SHALL, with AGC_LFSR_WRAP_DET_EN defined, include the seed register and NBITS comparators, and drive wrap_o per REQ-024.
REQ-029 SHALL, without AGC_LFSR_WRAP_DET_EN, omit the seed register and comparators and tie wrap_o to 0; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the FSM state enum, the NBITS maximum constant (8) and the default LEN/TAP/SEED constants in package agc_lfsr_pkg.
REQ-031 SHALL put the combinational NBITS-step leap function, which outputs the next state, the new bits and the intermediate states, in sub-module agc_lfsr_leap.
REQ-032 SHALL check the parameter ranges at elaboration and raise a fatal error when one is out of range.

Verification
REQ-033 SHALL cover: defaults, reset, start_i, then en_i=1 -> out_o=0 for advancing cycles 1-8; cycle 9 out_o=4'b0101 with valid_o=1.
REQ-034 SHALL cover: en_i toggled 1/0 in RUN -> valid_o follows en_i one cycle later; the out_o sequence equals the continuous-run sequence.
REQ-035 SHALL cover: seed_wr_i=1 with seed_i=0 -> state=SEED and a 1-cycle lockup_o; seed_wr_i together with en_i -> no advance and valid_o=0.
REQ-036 SHALL cover: start_i and stop_i in the same cycle while in RUN -> IDLE, running_o=0 next cycle, state unchanged.
REQ-037 SHALL cover: with macro defined, LFSR_LEN=5, TAP=3, NBITS=1, SEED=1 and en_i held -> wrap_o pulses on advancing cycles 31 and 62 only; with NBITS=4 the first wrap_o pulse is on cycle 8.
REQ-038 SHALL cover: rst_i asserted during RUN with en_i=1 -> the next cycle shows out_o=0, valid_o=0, IDLE, and state=SEED.

Source files
------------

// File: rtl/agc_lfsr_pkg.sv
// -----------------------------------------------------------------------------
// agc_lfsr_pkg
// Shared definitions for the agc_lfsr_gen block.
//   fsm_state_e  : run/idle control state
//   NBITS_MAX    : largest number of LFSR steps allowed per clock
//   DEFAULT_*    : default polynomial length, second tap and seed
// -----------------------------------------------------------------------------
package agc_lfsr_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fsm_state_e;

   localparam int          NBITS_MAX    = 8;
   localparam int          LEN_MIN      = 5;
   localparam int          LEN_MAX      = 64;
   localparam int          DEFAULT_LEN  = 35;
   localparam int          DEFAULT_TAP  = 33;
   localparam logic [63:0] DEFAULT_SEED = 64'd1;

endpackage : agc_lfsr_pkg

// File: rtl/agc_lfsr_leap.sv
// -----------------------------------------------------------------------------
// agc_lfsr_leap
// Purely combinational NBITS-step advance of a two-tap Fibonacci LFSR.
// Each step: b = x[LFSR_LEN-1] ^ x[TAP-1]; x = {x[LFSR_LEN-2:0], b}.
// Ports:
//   state_i  : current LFSR state
//   next_o   : state after NBITS steps
//   bits_o   : new bit of each step, bits_o[0] from the first step
//   inter_o  : state after each step (inter_o[k] after step k); present only
//              when AGC_LFSR_WRAP_DET_EN is defined, since nothing else
//              consumes it
// Macro: AGC_LFSR_WRAP_DET_EN
// -----------------------------------------------------------------------------
module agc_lfsr_leap
   import agc_lfsr_pkg::*;
#(
   parameter int LFSR_LEN = DEFAULT_LEN,
   parameter int TAP      = DEFAULT_TAP,
   parameter int NBITS    = 4
) (
   input  logic [LFSR_LEN-1:0]            state_i,
   output logic [LFSR_LEN-1:0]            next_o,
   output logic [NBITS-1:0]               bits_o
`ifdef AGC_LFSR_WRAP_DET_EN
   ,
   output logic [NBITS-1:0][LFSR_LEN-1:0] inter_o
`endif
);

   // chain_w[k] is the state after k steps; chain_w[0] is the input state.
   logic [LFSR_LEN-1:0] chain_w [NBITS+1];

   assign chain_w[0] = state_i;

   for (genvar gi = 0; gi < NBITS; gi++) begin : g_step
      logic fb_w;
      assign fb_w           = chain_w[gi][LFSR_LEN-1] ^ chain_w[gi][TAP-1];
      assign chain_w[gi+1]  = {chain_w[gi][LFSR_LEN-2:0], fb_w};
      assign bits_o[gi]     = fb_w;
`ifdef AGC_LFSR_WRAP_DET_EN
      assign inter_o[gi]    = chain_w[gi+1];
`endif
   end

   assign next_o = chain_w[NBITS];

endmodule : agc_lfsr_leap

// File: rtl/agc_lfsr_gen.sv
// -----------------------------------------------------------------------------
// agc_lfsr_gen
// Multi-bit-per-clock LFSR bit generator with run/idle control, seed loading,
// all-zero lockup recovery and optional wrap (period) detection.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, highest priority
//   start_i    : IDLE -> RUN request
//   stop_i     : RUN -> IDLE request (wins over start_i), state retained
//   en_i       : advance NBITS steps this clock while in RUN
//   seed_wr_i  : load seed_i (zero falls back to SEED), no advance that cycle
//   seed_i     : seed value
//   out_o      : generated bits, out_o[0] oldest; held when not advancing
//   valid_o    : out_o was refreshed by the previous clock
//   lockup_o   : one-cycle pulse on zero-seed fallback or zero-state reload
//   wrap_o     : one-cycle pulse when a step revisits the last loaded seed
//   running_o  : FSM is in RUN
// Macro: AGC_LFSR_WRAP_DET_EN builds the seed register and comparators that
// drive wrap_o; without it wrap_o is tied low.
// -----------------------------------------------------------------------------
module agc_lfsr_gen
   import agc_lfsr_pkg::*;
#(
   parameter int                   LFSR_LEN = DEFAULT_LEN,
   parameter int                   TAP      = DEFAULT_TAP,
   parameter int                   NBITS    = 4,
   parameter logic [LFSR_LEN-1:0]  SEED     = LFSR_LEN'(DEFAULT_SEED)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic                en_i,
   input  logic                seed_wr_i,
   input  logic [LFSR_LEN-1:0] seed_i,
   output logic [NBITS-1:0]    out_o,
   output logic                valid_o,
   output logic                lockup_o,
   output logic                wrap_o,
   output logic                running_o
);

   // Elaboration-time parameter range checks.
   if (LFSR_LEN < LEN_MIN || LFSR_LEN > LEN_MAX) begin : g_bad_len
      $fatal(1, "agc_lfsr_gen: LFSR_LEN=%0d out of range 5..64", LFSR_LEN);
   end
   if (TAP < 1 || TAP >= LFSR_LEN) begin : g_bad_tap
      $fatal(1, "agc_lfsr_gen: TAP=%0d must be 1..LFSR_LEN-1", TAP);
   end
   if (NBITS < 1 || NBITS > NBITS_MAX) begin : g_bad_nbits
      $fatal(1, "agc_lfsr_gen: NBITS=%0d out of range 1..8", NBITS);
   end
   if (SEED == '0) begin : g_bad_seed
      $fatal(1, "agc_lfsr_gen: SEED must be nonzero");
   end

   fsm_state_e          fsm_q,    fsm_d;
   logic [LFSR_LEN-1:0] state_q,  state_d;
   logic [NBITS-1:0]    out_q,    out_d;
   logic                valid_q,  valid_d;
   logic                lockup_q, lockup_d;

   logic [LFSR_LEN-1:0] next_w;
   logic [NBITS-1:0]    bits_w;
   logic [LFSR_LEN-1:0] load_val_w;
   logic                advance_w;

`ifdef AGC_LFSR_WRAP_DET_EN
   logic [NBITS-1:0][LFSR_LEN-1:0] inter_w;
`endif

   agc_lfsr_leap #(
      .LFSR_LEN (LFSR_LEN),
      .TAP      (TAP),
      .NBITS    (NBITS)
   ) u_leap (
      .state_i  (state_q),
      .next_o   (next_w),
      .bits_o   (bits_w)
`ifdef AGC_LFSR_WRAP_DET_EN
      ,
      .inter_o  (inter_w)
`endif
   );

   // An all-zero seed would lock the LFSR, so it is replaced by SEED.
   assign load_val_w = (seed_i == '0) ? SEED : seed_i;

   // A genuine advance: RUN, enabled, no seed write, and a live state.
   assign advance_w  = !seed_wr_i && (fsm_q == ST_RUN) && en_i && (state_q != '0);

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      out_d    = out_q;
      valid_d  = 1'b0;
      lockup_d = 1'b0;

      unique case (fsm_q)
         ST_IDLE: if (start_i) fsm_d = ST_RUN;
         ST_RUN:  if (stop_i)  fsm_d = ST_IDLE;
         default: fsm_d = ST_IDLE;
      endcase

      if (seed_wr_i) begin
         state_d  = load_val_w;
         lockup_d = (seed_i == '0);
      end else if ((fsm_q == ST_RUN) && en_i) begin
         if (state_q == '0) begin
            // Recovery path: reload instead of advancing, no new bits.
            state_d  = SEED;
            lockup_d = 1'b1;
         end else begin
            state_d  = next_w;
            out_d    = bits_w;
            valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q    <= ST_IDLE;
         state_q  <= SEED;
         out_q    <= '0;
         valid_q  <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         lockup_q <= lockup_d;
      end
   end

`ifdef AGC_LFSR_WRAP_DET_EN
   // Remember the last value actually loaded into the state and flag any
   // intermediate step that lands back on it.
   logic [LFSR_LEN-1:0] seed_q, seed_d;
   logic                wrap_q, wrap_d;
   logic [NBITS-1:0]    hit_w;

   for (genvar gi = 0; gi < NBITS; gi++) begin : g_cmp
      assign hit_w[gi] = (inter_w[gi] == seed_q);
   end

   always_comb begin
      seed_d = seed_wr_i ? load_val_w : seed_q;
      wrap_d = advance_w && (|hit_w);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seed_q <= SEED;
         wrap_q <= 1'b0;
      end else begin
         seed_q <= seed_d;
         wrap_q <= wrap_d;
      end
   end

   assign wrap_o = wrap_q;
`else
   // advance_w only feeds wrap detection.
   logic unused_advance_w;
   assign unused_advance_w = advance_w;
   assign wrap_o = 1'b0;
`endif

   assign out_o     = out_q;
   assign valid_o   = valid_q;
   assign lockup_o  = lockup_q;
   assign running_o = (fsm_q == ST_RUN);

endmodule : agc_lfsr_gen
